// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } mem_arb_state_e;

  typedef enum logic {
    OWNER_IF,
    OWNER_LSU
  } mem_arb_owner_e;

  localparam logic [3:0] MEM_ARB_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and DRAM bus bundle for the shared memory port.
// Signal suffixes are from the arbiter's point of view.
interface mem_port_arbiter_if;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rvalid_i, mem_rdata_i
  );

  // Requester / memory side
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Response watchdog: counts waiting cycles, flags a hung memory (sticky).
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expire,
  output logic err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // Fires in the cycle the count would reach TIMEOUT; err is visible in that same cycle
  assign expire = run && (cnt_q == CW'(TIMEOUT - 1));
  assign err    = err_q | expire;

  // Next count: reload on grant, advance while waiting
  always_comb begin
    cnt_d = cnt_q;
    if (start)    cnt_d = '0;
    else if (run) cnt_d = cnt_q + CW'(1);
  end

  // Counter and sticky error registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared DRAM port arbiter: IF vs LSU, one outstanding transaction,
// starvation guard, flush kill of fetch responses, watchdog recovery.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LSU_MAX_BURST = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_i,
  mem_port_arbiter_if.slave   bus,
  output logic                err_o
);

  localparam logic [2:0] BURST_LIMIT = 3'(LSU_MAX_BURST);

  mem_arb_state_e state_q, state_d;
  mem_arb_owner_e owner_q, owner_d;
  logic           kill_q, kill_d;
  logic [2:0]     streak_q, streak_d;

  logic        wd_start, wd_run, wd_expire, wd_err;
  logic        arb_en;
  logic [31:0] rsp_data;

  // Kept outside the main comb block so expire does not feed back into its own process
  assign wd_run = reset && (state_q == WAIT_RESP) && !bus.mem_rvalid_i;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .start  (wd_start),
    .run    (wd_run),
    .expire (wd_expire),
    .err    (wd_err)
  );

  assign err_o = wd_err;

  // Response routing, arbitration and next-state; everything gated off while in reset
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    kill_d   = kill_q;
    streak_d = streak_q;
    wd_start = 1'b0;
    arb_en   = 1'b0;
    rsp_data = '0;

    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.lsu_gnt_o    = 1'b0;
    bus.lsu_rvalid_o = 1'b0;
    bus.lsu_rdata_o  = '0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_be_o     = '0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;

    if (reset) begin
      if (state_q == WAIT_RESP) begin
        if (flush_i && owner_q == OWNER_IF) kill_d = 1'b1;
        if (bus.mem_rvalid_i || wd_expire) begin
          rsp_data = wd_expire ? '0 : bus.mem_rdata_i;
          if (owner_q == OWNER_IF) begin
            // A flush in the response cycle also suppresses the fetch data
            if (!(kill_q || flush_i)) begin
              bus.if_rvalid_o = 1'b1;
              bus.if_rdata_o  = rsp_data;
            end
          end else begin
            bus.lsu_rvalid_o = 1'b1;
            bus.lsu_rdata_o  = rsp_data;
          end
          state_d = IDLE;
        end
      end

      arb_en = (state_q == IDLE) || bus.mem_rvalid_i;

      if (arb_en) begin
        if (bus.lsu_req_i && (!bus.if_req_i || streak_q != BURST_LIMIT)) begin
          bus.lsu_gnt_o   = 1'b1;
          bus.mem_req_o   = 1'b1;
          bus.mem_we_o    = bus.lsu_we_i;
          bus.mem_be_o    = bus.lsu_be_i;
          bus.mem_addr_o  = bus.lsu_addr_i;
          bus.mem_wdata_o = bus.lsu_wdata_i;
          owner_d         = OWNER_LSU;
          streak_d        = bus.if_req_i ? streak_q + 3'd1 : 3'd0;
          kill_d          = 1'b0;
          wd_start        = 1'b1;
          state_d         = WAIT_RESP;
        end else if (bus.if_req_i) begin
          bus.if_gnt_o    = 1'b1;
          bus.mem_req_o   = 1'b1;
          bus.mem_be_o    = MEM_ARB_BE_FULL;
          bus.mem_addr_o  = bus.if_addr_i;
          owner_d         = OWNER_IF;
          streak_d        = 3'd0;
          kill_d          = 1'b0;
          wd_start        = 1'b1;
          state_d         = WAIT_RESP;
        end
      end
    end
  end

  // State, owner, kill and streak registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_IF;
      kill_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      kill_q   <= kill_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (LSU_MAX_BURST=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  typedef struct {
    logic        rst, flush, if_req;
    logic [31:0] if_addr;
    logic        lreq, lwe;
    logic [3:0]  lbe;
    logic [31:0] laddr, lwd;
    logic        mrv;
    logic [31:0] mrd;
  } in_t;

  typedef struct {
    logic        ifg, ifrv;
    logic [31:0] ifrd;
    logic        lg, lrv;
    logic [31:0] lrd;
    logic        mreq, mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr, mwd;
    logic        err;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic clock;
  logic reset;
  logic flush_i;
  logic err_o;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.LSU_MAX_BURST(4), .TIMEOUT(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush_i),
    .bus     (bus),
    .err_o   (err_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic in_t mk_in(input logic rst, input logic flush, input logic if_req,
                                input logic [31:0] if_addr, input logic lreq, input logic lwe,
                                input logic [3:0] lbe, input logic [31:0] laddr,
                                input logic [31:0] lwd, input logic mrv, input logic [31:0] mrd);
    in_t v;
    v.rst = rst; v.flush = flush; v.if_req = if_req; v.if_addr = if_addr;
    v.lreq = lreq; v.lwe = lwe; v.lbe = lbe; v.laddr = laddr; v.lwd = lwd;
    v.mrv = mrv; v.mrd = mrd;
    return v;
  endfunction

  function automatic exp_t mk_ex(input logic ifg, input logic ifrv, input logic [31:0] ifrd,
                                 input logic lg, input logic lrv, input logic [31:0] lrd,
                                 input logic mreq, input logic mwe, input logic [3:0] mbe,
                                 input logic [31:0] maddr, input logic [31:0] mwd,
                                 input logic err);
    exp_t v;
    v.ifg = ifg; v.ifrv = ifrv; v.ifrd = ifrd; v.lg = lg; v.lrv = lrv; v.lrd = lrd;
    v.mreq = mreq; v.mwe = mwe; v.mbe = mbe; v.maddr = maddr; v.mwd = mwd; v.err = err;
    return v;
  endfunction

  function automatic in_t quiet(input logic mrv, input logic [31:0] mrd);
    return mk_in(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, mrv, mrd);
  endfunction

  function automatic exp_t none(input logic err);
    return mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, err);
  endfunction

  task automatic add(input string name, input in_t i, input exp_t e);
    vec_t v;
    v.name = name; v.i = i; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t v);
    reset            = v.rst;
    flush_i          = v.flush;
    bus.if_req_i     = v.if_req;
    bus.if_addr_i    = v.if_addr;
    bus.lsu_req_i    = v.lreq;
    bus.lsu_we_i     = v.lwe;
    bus.lsu_be_i     = v.lbe;
    bus.lsu_addr_i   = v.laddr;
    bus.lsu_wdata_i  = v.lwd;
    bus.mem_rvalid_i = v.mrv;
    bus.mem_rdata_i  = v.mrd;
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk(tag, "if_gnt",     32'(bus.if_gnt_o),     32'(e.ifg));
    chk(tag, "if_rvalid",  32'(bus.if_rvalid_o),  32'(e.ifrv));
    chk(tag, "if_rdata",   bus.if_rdata_o,        e.ifrd);
    chk(tag, "lsu_gnt",    32'(bus.lsu_gnt_o),    32'(e.lg));
    chk(tag, "lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(e.lrv));
    chk(tag, "lsu_rdata",  bus.lsu_rdata_o,       e.lrd);
    chk(tag, "mem_req",    32'(bus.mem_req_o),    32'(e.mreq));
    chk(tag, "mem_we",     32'(bus.mem_we_o),     32'(e.mwe));
    chk(tag, "mem_be",     32'(bus.mem_be_o),     32'(e.mbe));
    chk(tag, "mem_addr",   bus.mem_addr_o,        e.maddr);
    chk(tag, "mem_wdata",  bus.mem_wdata_o,       e.mwd);
    chk(tag, "err",        32'(err_o),            32'(e.err));
  endtask

  initial begin
    int  ms;
    bit  have_prev;
    bit  prev_lsu;
    bit  exp_lsu;
    string tag;

    apply(mk_in(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));

    // Reset held with activity on the inputs
    add("rst_hold", mk_in(0, 0, 1, 32'h10, 0, 0, 4'h0, 0, 0, 1, 32'h123), none(0));
    // Solo fetch, 2-cycle memory
    add("if_grant", mk_in(1, 0, 1, 32'h10, 0, 0, 4'h0, 0, 0, 0, 0),
        mk_ex(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h10, 0, 0));
    add("if_wait",  quiet(0, 0), none(0));
    add("if_resp",  quiet(1, 32'h00500093),
        mk_ex(0, 1, 32'h00500093, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    add("idle1",    quiet(0, 0), none(0));
    // Store with partial byte enables
    add("st_grant", mk_in(1, 0, 0, 0, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0),
        mk_ex(0, 0, 0, 1, 0, 0, 1, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0));
    add("st_ack",   quiet(1, 0), mk_ex(0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0));
    // Contention, 1-cycle memory: L L L L I L
    add("ct_L1", mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 0, 0),
        mk_ex(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0));
    add("ct_L2", mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 1, 32'hA1),
        mk_ex(0, 0, 0, 1, 1, 32'hA1, 1, 0, 4'hF, 32'h300, 0, 0));
    add("ct_L3", mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 1, 32'hA2),
        mk_ex(0, 0, 0, 1, 1, 32'hA2, 1, 0, 4'hF, 32'h300, 0, 0));
    add("ct_L4", mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 1, 32'hA3),
        mk_ex(0, 0, 0, 1, 1, 32'hA3, 1, 0, 4'hF, 32'h300, 0, 0));
    add("ct_I",  mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 1, 32'hA4),
        mk_ex(1, 0, 0, 0, 1, 32'hA4, 1, 0, 4'hF, 32'h40, 0, 0));
    add("ct_L5", mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, 1, 32'hB1),
        mk_ex(0, 1, 32'hB1, 1, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0));
    add("ct_end", quiet(1, 32'hC1), mk_ex(0, 0, 0, 0, 1, 32'hC1, 0, 0, 4'h0, 0, 0, 0));
    // Flush after fetch grant; pending LSU granted in the response cycle
    add("fl_grant", mk_in(1, 0, 1, 32'h80, 0, 0, 4'h0, 0, 0, 0, 0),
        mk_ex(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h80, 0, 0));
    add("fl_pulse", mk_in(1, 1, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0), none(0));
    add("fl_wait",  mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0), none(0));
    add("fl_resp",  mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h400, 0, 1, 32'h77),
        mk_ex(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0));
    add("fl_lresp", quiet(1, 32'h88), mk_ex(0, 0, 0, 0, 1, 32'h88, 0, 0, 4'h0, 0, 0, 0));
    // Flush in the same cycle as the fetch response
    add("fl2_grant", mk_in(1, 0, 1, 32'h90, 0, 0, 4'h0, 0, 0, 0, 0),
        mk_ex(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h90, 0, 0));
    add("fl2_same",  mk_in(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h99), none(0));
    add("late_idle", quiet(1, 32'h5), none(0));
    // Watchdog: LSU load, memory silent, expiry 8 cycles after grant
    add("wd_grant", mk_in(1, 0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 0, 0),
        mk_ex(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h500, 0, 0));
    for (int k = 1; k <= 7; k++) add($sformatf("wd_wait%0d", k), quiet(0, 0), none(0));
    add("wd_expire", quiet(0, 32'hFFFF), mk_ex(0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1));
    add("wd_next",   mk_in(1, 0, 1, 32'h14, 0, 0, 4'h0, 0, 0, 0, 0),
        mk_ex(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h14, 0, 1));
    add("wd_nresp",  quiet(1, 32'h1234), mk_ex(0, 1, 32'h1234, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1));
    // Reset in the middle of a store
    add("rs_grant", mk_in(1, 0, 0, 0, 1, 1, 4'hC, 32'h600, 32'hCAFEF00D, 0, 0),
        mk_ex(0, 0, 0, 1, 0, 0, 1, 1, 4'hC, 32'h600, 32'hCAFEF00D, 1));
    add("rs_mid",  mk_in(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h42), none(0));
    add("rs_late", quiet(1, 32'h43), none(0));
    add("rs_idle", quiet(0, 0), none(0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clock);
      apply(tbl[k].i);
      #3;
      check_all(tbl[k].name, tbl[k].e);
    end

    // Longer contention run against a small grant-order model
    ms = 0;
    have_prev = 1'b0;
    prev_lsu = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      apply(mk_in(1, 0, 1, 32'h40, 1, 0, 4'hF, 32'h300, 0, have_prev, 32'h100 + 32'(c)));
      #3;
      tag = $sformatf("burst%0d", c);
      exp_lsu = (ms != 4);
      chk(tag, "lsu_gnt", 32'(bus.lsu_gnt_o), 32'(exp_lsu));
      chk(tag, "if_gnt",  32'(bus.if_gnt_o),  32'(!exp_lsu));
      if (have_prev) begin
        chk(tag, "lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(prev_lsu));
        chk(tag, "if_rvalid",  32'(bus.if_rvalid_o),  32'(!prev_lsu));
        chk(tag, "rdata", prev_lsu ? bus.lsu_rdata_o : bus.if_rdata_o, 32'h100 + 32'(c));
      end
      ms = exp_lsu ? ms + 1 : 0;
      prev_lsu = exp_lsu;
      have_prev = 1'b1;
    end
    @(negedge clock);
    apply(quiet(1, 32'h200));
    #3;
    chk("burst_drain", "lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(prev_lsu));
    chk("burst_drain", "if_rvalid",  32'(bus.if_rvalid_o),  32'(!prev_lsu));
    chk("burst_drain", "mem_req",    32'(bus.mem_req_o),    32'd0);
    @(negedge clock);
    apply(quiet(0, 0));
    #3;
    check_all("post_idle", none(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared DRAM port, sitting between the instruction-fetch requester and the load/store unit on one side and main memory on the other. It grants one transaction at a time, routes the response back to its owner, and prevents fetch starvation under long load/store runs. It also drops fetch responses invalidated by a pipeline flush and recovers from a hung memory through a watchdog.

## Interface
Parameters:
- `LSU_MAX_BURST`, 4: consecutive LSU grants allowed while IF is waiting.
- `TIMEOUT`, 64: cycles in `WAIT_RESP` before the watchdog fires.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush_i` in 1: pipeline flush from EX.
- `if_req_i` in 1: fetch read request.
- `if_addr_i` in 32: fetch address.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: fetch data valid.
- `if_rdata_o` out 32: fetch data.
- `lsu_req_i` in 1: LSU request.
- `lsu_we_i` in 1: 1 = store.
- `lsu_be_i` in 4: byte enables.
- `lsu_addr_i` in 32: LSU address.
- `lsu_wdata_i` in 32: store data.
- `lsu_gnt_o` out 1: LSU request accepted this cycle.
- `lsu_rvalid_o` out 1: LSU load data or store acknowledge.
- `lsu_rdata_o` out 32: load data.
- `mem_req_o` out 1: transaction issue to DRAM.
- `mem_we_o` out 1: write strobe.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: address.
- `mem_wdata_o` out 32: write data.
- `mem_rvalid_i` in 1: DRAM response, one pulse per transaction, reads and writes alike.
- `mem_rdata_i` in 32: DRAM read data.
- `err_o` out 1: sticky watchdog error.

## Operation
- FSM states:
  - `IDLE`: no transaction outstanding.
  - `WAIT_RESP`: one transaction outstanding. At most one outstanding transaction at any time.
- Arbitration happens in `IDLE` and in the `WAIT_RESP` cycle where `mem_rvalid_i` = 1 (turnaround). It is combinational from the request inputs.
  - Only one requester active: that requester wins.
  - Both active: LSU wins, unless `streak` == `LSU_MAX_BURST`; then IF wins.
- On a grant:
  - Pulse the winner's `*_gnt_o`.
  - Drive `mem_req_o` = 1 and `mem_*` from the winner. IF grants drive `we`=0 and `be`=4'hF.
  - Register `owner` (IF/LSU), clear `kill`, load the watchdog with 0, go to `WAIT_RESP`.
- `streak` (3 bits):
  - LSU grant with `if_req_i` = 1: increment.
  - IF grant, or LSU grant with `if_req_i` = 0: clear.
- `WAIT_RESP`:
  - `mem_rvalid_i` = 1: raise the owner's `*_rvalid_o`, pass `mem_rdata_i` through to the owner's `*_rdata_o`. Suppress `if_rvalid_o` when `kill` = 1. Return to `IDLE` unless a turnaround grant occurs.
  - `flush_i` = 1 while `owner` = IF: set `kill`. The transaction still completes at the memory.
  - `flush_i` = 1 while `owner` = LSU: ignored.
- Watchdog:
  - Increments every `WAIT_RESP` cycle without `mem_rvalid_i`.
  - On reaching `TIMEOUT`: set `err_o`, pulse the owner's `rvalid` with `rdata` = 0 (IF still subject to `kill`), return to `IDLE`.
  - A late `mem_rvalid_i` arriving in `IDLE` is ignored.
- Inactive `rdata` outputs drive 0. Inactive `mem_*` outputs drive 0.

## Timing
- Reset (asynchronous, `reset` = 0):
  - State `IDLE`; `owner`, `kill`, `streak`, watchdog and `err_o` all 0.
  - All outputs 0.
  - An in-flight transaction is abandoned and no `rvalid` is produced.
- Grant latency: 0 cycles. `gnt` and `mem_req_o` appear in the same cycle as the request when the arbiter is free.
- Earliest response: the cycle after the grant. Response to requester: 0 added cycles (combinational pass-through).
- Back-to-back throughput: one transaction per memory latency. No idle bubble at turnaround.
- Requesters hold `req` and address stable until they see `gnt`.
- `err_o` clears only on reset.
- `flush_i` and `mem_rvalid_i` in the same cycle for an IF transaction: the response is suppressed.

## Structure
- Add to `CORE_PKG`:
  - `mem_arb_state_e` {`IDLE`, `WAIT_RESP`}.
  - `mem_arb_owner_e` {`OWNER_IF`, `OWNER_LSU`}.
  - Constant `MEM_ARB_BE_FULL` = 4'hF.
- Sub-module `mem_arb_watchdog`: counter plus sticky error. Inputs: `clock`, `reset`, `start`, `run`. Outputs: `expire`, `err`.
- Everything else lives in `mem_port_arbiter`.

## Test plan
- Solo fetch: `if_req_i` = 1 with addr 0x10; memory answers 2 cycles later with 0x00500093 → `if_gnt_o` pulses in cycle 0, `if_rvalid_o` = 1 with `if_rdata_o` = 0x00500093 in cycle 2, `lsu_rvalid_o` stays 0.
- Contention and starvation: both requesters held continuously, 1-cycle memory → grants in the order L, L, L, L, I, L…; `streak` returns to 0 after the IF grant.
- Store: `lsu_we_i` = 1, `be` = 4'h3, addr 0x200, wdata 0xDEADBEEF → `mem_we_o` = 1, `mem_be_o` = 4'h3, `mem_wdata_o` = 0xDEADBEEF; the ack produces `lsu_rvalid_o`.
- Flush: IF granted, `flush_i` pulsed in the next cycle, memory responds 3 cycles after the grant → no `if_rvalid_o`; a pending LSU request is granted in the same response cycle.
- Watchdog: `TIMEOUT` = 8, memory never responds → `lsu_rvalid_o` with `rdata` = 0 at cycle 8, `err_o` = 1 and stays set; the next request is served normally.
- Reset mid-transaction: `reset` driven low while in `WAIT_RESP` → all outputs 0 immediately; a later `mem_rvalid_i` is ignored.
